// File: rtl/pmem_loader.sv
// pmem_loader: assembles a big-endian byte stream into 16-bit program memory
// words. It writes each word to consecutive addresses and stops at the first
// 16'hFFFF terminator word, or after DEPTH words (overflow). done releases the
// core from reset.
//
// Optional feature (compile-time macro PMEM_LOADER_CHECKSUM_EN):
//   After the last word, one extra byte is accepted. That byte must equal the
//   XOR of every data byte transferred. If it does not, chk_err is set.
//   With the macro undefined, the CHK state and the accumulator are absent,
//   and chk_err is tied to 0.
//
// Ports:
//   clk, rst        clock (posedge), synchronous active-low reset
//   in_data/valid   byte stream input; in_ready is the accept handshake
//   wr_en/addr/data one-cycle program memory write strobe with address/word
//   word_count      number of words written so far (0..DEPTH)
//   done            load complete, held until reset
//   overflow        DEPTH words written without a terminator
//   chk_err         checksum byte mismatch (checksum build only)
module pmem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              overflow,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    HI,
    LO,
    WR,
`ifdef PMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DN
  } state_t;

  // word_count value while the DEPTH-th word is in WR (before its increment)
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH-1);

  state_t state;
  logic   xfer;

  // in_ready is a state decode gated by rst. This keeps it low during reset
  // and high on the very first cycle after reset is released.
`ifdef PMEM_LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic       chk_err_q;
  assign in_ready = rst && (state == HI || state == LO || state == CHK);
  assign chk_err  = chk_err_q;
`else
  assign in_ready = rst && (state == HI || state == LO);
  assign chk_err  = 1'b0;
`endif

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HI;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      wr_en      <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
      acc        <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        HI: if (xfer) begin
          wr_data[15:8] <= in_data;
`ifdef PMEM_LOADER_CHECKSUM_EN
          acc           <= acc ^ in_data;
`endif
          state         <= LO;
        end
        LO: if (xfer) begin
          wr_data[7:0] <= in_data;
`ifdef PMEM_LOADER_CHECKSUM_EN
          acc          <= acc ^ in_data;
`endif
          // The strobe is registered here, so it is high exactly during WR.
          wr_en        <= 1'b1;
          state        <= LO == LO ? WR : WR;
        end
        WR: begin
          wr_addr    <= wr_addr + 1'b1;
          word_count <= word_count + 1'b1;
          // The terminator takes priority. A FFFF in the last slot is not an overflow.
          if (wr_data == 16'hFFFF || word_count == LAST_CNT) begin
            overflow <= (wr_data != 16'hFFFF);
`ifdef PMEM_LOADER_CHECKSUM_EN
            state    <= CHK;
`else
            state    <= DN;
            done     <= 1'b1;
`endif
          end else begin
            state <= HI;
          end
        end
`ifdef PMEM_LOADER_CHECKSUM_EN
        CHK: if (xfer) begin
          chk_err_q <= (in_data != acc);
          done      <= 1'b1;
          state     <= DN;
        end
`endif
        DN: ;
        default: state <= HI;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Self-checking bench for pmem_loader. For each load, the expected writes are
// computed from the word list and pushed into a queue. A monitor pops and
// compares the queue on every wr_en. Build with +define+PMEM_LOADER_CHECKSUM_EN
// to exercise the checksum byte.
module tb_pmem_loader;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [ADDR_W:0]   word_count;
  logic              done;
  logic              overflow;
  logic              chk_err;

  pmem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .done(done), .overflow(overflow), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit tog   = 1'b0;

  logic [15:0]        stim[$];   // words offered to the loader
  logic [ADDR_W+15:0] exp_q[$];  // expected {addr, data} writes

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      chk("rdy_in_wr", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'(wr_data), 32'hDEAD_0000);
      end else begin
        logic [ADDR_W+15:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+15:16]));
        chk("wr_data", 32'(wr_data), 32'(e[15:0]));
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en), 32'd0);
    chk("rst_done",     32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_chk_err",  32'(chk_err), 32'd0);
    chk("rst_count",    32'(word_count), 32'd0);
    chk("rst_addr",     32'(wr_addr), 32'd0);
    chk("rst_data",     32'(wr_data), 32'd0);
    chk("pending_rst",  32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    #1 chk("rdy_after_rst", 32'(in_ready), 32'd1);
  endtask

  // Offer one byte and gap the valid line according to the mode:
  // 0 = valid held high, 1 = valid toggled every cycle, 2 = random.
  // The task returns just after the posedge that transfers the byte.
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit sent = 1'b0;
    int t = 0;
    while (!sent) begin
      logic v;
      @(negedge clk);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) begin v = tog; tog = ~tog; end
      else                v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? b : 8'($urandom);
      if (v) begin
        chk("rdy_accept", 32'(in_ready), 32'd1);
        sent = 1'b1;
      end
      t++;
      if (!sent && t > 64) begin
        chk("send_timeout", 32'd0, 32'd1);
        sent = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  // Load the words in stim. The model truncates the list at the first FFFF or
  // at DEPTH words, then predicts writes, count, overflow and checksum.
  task automatic run_load(input bit do_rst, input int mode, input int cmode,
                          input logic [7:0] cval, input int dn_cycles);
    logic [15:0] snd[$];
    logic [7:0]  acc = 8'h00;
    bit          ov = 1'b1;
    bit          cerr = 1'b0;
    if (do_rst) reset_dut();
    foreach (stim[i]) begin
      if (snd.size() == DEPTH) break;
      snd.push_back(stim[i]);
      if (stim[i] == 16'hFFFF) begin ov = 1'b0; break; end
    end
    foreach (snd[k]) begin
      exp_q.push_back({ADDR_W'(k), snd[k]});
      acc = acc ^ snd[k][15:8] ^ snd[k][7:0];
    end
    foreach (snd[k]) begin
      send_byte(snd[k][15:8], mode);
      send_byte(snd[k][7:0], mode);
      @(negedge clk);
      chk("wr_latency", 32'(wr_en), 32'd1);
    end
`ifdef PMEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] cb;
      cb = (cmode == 0) ? acc : cval;
      cerr = (cb != acc);
      send_byte(cb, mode);
    end
`else
    if (cmode != 0) cerr = (cval != cval);
`endif
    for (int c = 0; c < dn_cycles; c++) begin
      @(negedge clk);
      chk("dn_done",     32'(done), 32'd1);
      chk("dn_in_ready", 32'(in_ready), 32'd0);
      chk("dn_count",    32'(word_count), 32'(snd.size()));
      chk("dn_overflow", 32'(overflow), 32'(ov));
      chk("dn_chk_err",  32'(chk_err), 32'(cerr));
      in_valid = 1'b1;
      in_data  = 8'h55;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pending_end", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // 12 34 FF FF with valid held high; then bytes 55 are offered in DN.
    stim = '{16'h1234, 16'hFFFF};
    run_load(1'b1, 0, 0, 8'h00, 10);

    // 16 words with no terminator cause an overflow.
    stim.delete();
    for (int i = 1; i <= DEPTH; i++) stim.push_back(16'(i));
    run_load(1'b1, 0, 0, 8'h00, 3);

    // Toggling valid must not cause partial-word loss.
    stim = '{16'h1234, 16'hFFFF};
    run_load(1'b1, 1, 0, 8'h00, 3);

    // Reset in LO after byte AB, with the low byte presented at the reset edge.
    reset_dut();
    send_byte(8'hAB, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hCD;
    @(negedge clk);
    chk("midrst_count", 32'(word_count), 32'd0);
    chk("midrst_addr",  32'(wr_addr), 32'd0);
    chk("midrst_rdy",   32'(in_ready), 32'd0);
    in_valid = 1'b0; rst = 1'b1;
    stim = '{16'h0007, 16'hFFFF};
    run_load(1'b0, 0, 0, 8'h00, 3);

`ifdef PMEM_LOADER_CHECKSUM_EN
    stim = '{16'h1234, 16'hFFFF};
    run_load(1'b1, 0, 1, 8'h26, 3);
    run_load(1'b1, 0, 1, 8'h00, 3);
`endif

    // Random loads use random gaps, random terminator placement and random checksum.
    for (int r = 0; r < 8; r++) begin
      stim.delete();
      for (int k = 0; k < DEPTH; k++) begin
        logic [15:0] w;
        do w = 16'($urandom); while (w == 16'hFFFF);
        stim.push_back(w);
      end
      if ($urandom_range(0, 1) == 1) stim[$urandom_range(0, DEPTH-1)] = 16'hFFFF;
      run_load(1'b1, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
               8'($urandom), 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
